// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: size codes, port indices and counter width helper for ram_arbiter
package ram_arb_pkg;
  localparam logic [1:0] SZ_WORD = 2'b11;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DMA = 1'b1;
  function automatic int cnt_w(input int max_burst);
    return $clog2(max_burst + 1);
  endfunction
endpackage

// File: rtl/ram_arb_pick.sv
// ram_arb_pick: combinational winner selection; RAM_ARB_FIXED_PRIO_EN gives port 0 absolute priority
module ram_arb_pick import ram_arb_pkg::*; #(
  parameter int MAX_BURST = 4,
  parameter int CW = cnt_w(MAX_BURST)
) (
  input  logic [1:0]    req,
  input  logic          last,
  input  logic [CW-1:0] cnt,
  output logic          any,
  output logic          win
);
  localparam logic [CW-1:0] MB = CW'(MAX_BURST);
  always_comb begin
    any = |req;
`ifdef RAM_ARB_FIXED_PRIO_EN
    win = ~req[0];
`else
    win = &req ? ((cnt != '0 && cnt < MB) ? last : ~last) : req[1];
`endif
  end
endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: two-port burst-limited round-robin RAM arbiter with 1-cycle response routing
// RAM_ARB_FIXED_PRIO_EN selects fixed port-0 priority instead of round-robin
module ram_arbiter import ram_arb_pkg::*; #(
  parameter int MAX_BURST = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        P0_REQ,
  input  logic        P0_WE,
  input  logic [1:0]  P0_WHBS,
  input  logic [31:0] P0_ADDR,
  input  logic [31:0] P0_WDATA,
  output logic        P0_GNT,
  output logic        P0_ACK,
  output logic        P0_ERR,
  output logic [31:0] P0_RDATA,
  input  logic        P1_REQ,
  input  logic        P1_WE,
  input  logic [1:0]  P1_WHBS,
  input  logic [31:0] P1_ADDR,
  input  logic [31:0] P1_WDATA,
  output logic        P1_GNT,
  output logic        P1_ACK,
  output logic        P1_ERR,
  output logic [31:0] P1_RDATA,
  output logic        RAM_WE,
  output logic [1:0]  RAM_RWHBS,
  output logic [1:0]  RAM_WWHBS,
  output logic [31:0] RAM_RADDR,
  output logic [31:0] RAM_WADDR,
  output logic [31:0] RAM_DIN,
  input  logic [31:0] RAM_DOUT,
  input  logic        RAM_RUNAL,
  input  logic        RAM_WUNAL
);
  localparam int CW = cnt_w(MAX_BURST);
  localparam logic [CW-1:0] MB = CW'(MAX_BURST);
  logic last, any, win, gnt, we, rd, pend_v, pend_p, pend_e;
  logic [CW-1:0] cnt;
  logic [1:0] sz;
  logic [31:0] addr, wdata;
  ram_arb_pick #(.MAX_BURST(MAX_BURST), .CW(CW)) u_pick (
    .req ({P1_REQ, P0_REQ}),
    .last(last),
    .cnt (cnt),
    .any (any),
    .win (win)
  );
  always_comb begin
    gnt = any & ~RST;
    we = win ? P1_WE : P0_WE;
    sz = win ? P1_WHBS : P0_WHBS;
    addr = win ? P1_ADDR : P0_ADDR;
    wdata = win ? P1_WDATA : P0_WDATA;
    rd = gnt & ~we;
    P0_GNT = gnt & (win == PORT_CPU);
    P1_GNT = gnt & (win == PORT_DMA);
    RAM_WE = gnt & we;
    RAM_WADDR = RAM_WE ? addr : '0;
    RAM_WWHBS = RAM_WE ? sz : '0;
    RAM_DIN = RAM_WE ? wdata : '0;
    RAM_RADDR = rd ? addr : '0;
    RAM_RWHBS = rd ? sz : '0;
    // gating with RST drops a response whose grant was followed by reset
    P0_ACK = pend_v & ~RST & ~pend_e & (pend_p == PORT_CPU);
    P1_ACK = pend_v & ~RST & ~pend_e & (pend_p == PORT_DMA);
    P0_ERR = pend_v & ~RST & pend_e & (pend_p == PORT_CPU);
    P1_ERR = pend_v & ~RST & pend_e & (pend_p == PORT_DMA);
    P0_RDATA = RAM_DOUT;
    P1_RDATA = RAM_DOUT;
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      last <= PORT_DMA;
      cnt <= '0;
      pend_v <= 1'b0;
      pend_p <= PORT_CPU;
      pend_e <= 1'b0;
    end else begin
      pend_v <= gnt;
      pend_p <= win;
      pend_e <= we ? RAM_WUNAL : RAM_RUNAL;
      if (gnt) begin
        last <= win;
        cnt <= (win != last) ? CW'(1) : (cnt == MB) ? cnt : cnt + 1'b1;
      end else begin
        cnt <= '0;
      end
    end
  end
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: randomized and directed checks of ram_arbiter against a transaction-level model
module tb_ram_arbiter;
  localparam int MB = 4;
  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic P0_REQ = 0, P0_WE = 0, P1_REQ = 0, P1_WE = 0;
  logic [1:0] P0_WHBS = 0, P1_WHBS = 0;
  logic [31:0] P0_ADDR = 0, P0_WDATA = 0, P1_ADDR = 0, P1_WDATA = 0;
  logic P0_GNT, P0_ACK, P0_ERR, P1_GNT, P1_ACK, P1_ERR;
  logic [31:0] P0_RDATA, P1_RDATA;
  logic RAM_WE, RAM_RUNAL, RAM_WUNAL;
  logic [1:0] RAM_RWHBS, RAM_WWHBS;
  logic [31:0] RAM_RADDR, RAM_WADDR, RAM_DIN, RAM_DOUT;
  logic [7:0] ram [512];
  logic [7:0] mem_m [512];
  int tests = 0, fails = 0;
  logic m_last = 1'b1;
  int m_run = 0;
  logic e_v = 0, e_p = 0, e_e = 0, e_load = 0;
  logic [31:0] e_data = 0, e_mask = 0;
  logic g0 = 0, g1 = 0, o_ack0, o_ack1, o_err0, o_err1;
  logic [31:0] o_rd;
  int seq_a [10];
  int seq_n = 0;

  ram_arbiter #(.MAX_BURST(MB)) dut (
    .CLK(CLK), .RST(RST),
    .P0_REQ(P0_REQ), .P0_WE(P0_WE), .P0_WHBS(P0_WHBS), .P0_ADDR(P0_ADDR), .P0_WDATA(P0_WDATA),
    .P0_GNT(P0_GNT), .P0_ACK(P0_ACK), .P0_ERR(P0_ERR), .P0_RDATA(P0_RDATA),
    .P1_REQ(P1_REQ), .P1_WE(P1_WE), .P1_WHBS(P1_WHBS), .P1_ADDR(P1_ADDR), .P1_WDATA(P1_WDATA),
    .P1_GNT(P1_GNT), .P1_ACK(P1_ACK), .P1_ERR(P1_ERR), .P1_RDATA(P1_RDATA),
    .RAM_WE(RAM_WE), .RAM_RWHBS(RAM_RWHBS), .RAM_WWHBS(RAM_WWHBS),
    .RAM_RADDR(RAM_RADDR), .RAM_WADDR(RAM_WADDR), .RAM_DIN(RAM_DIN),
    .RAM_DOUT(RAM_DOUT), .RAM_RUNAL(RAM_RUNAL), .RAM_WUNAL(RAM_WUNAL)
  );

  always #5 CLK = ~CLK;

  function automatic logic unal(input logic [1:0] s, input logic [31:0] a);
    return (s == 2'b11) ? |a[1:0] : (s == 2'b01) ? a[0] : 1'b0;
  endfunction
  function automatic int nb(input logic [1:0] s);
    return (s == 2'b11) ? 4 : (s == 2'b01) ? 2 : 1;
  endfunction
  function automatic logic [7:0] init_byte(input int i);
    return 8'(i * 37 + 5);
  endfunction

  // RAM environment: reloads a known pattern during reset, gates faulting stores
  assign RAM_RUNAL = unal(RAM_RWHBS, RAM_RADDR);
  assign RAM_WUNAL = unal(RAM_WWHBS, RAM_WADDR);
  always @(posedge CLK) begin
    if (RST) for (int i = 0; i < 512; i++) ram[i] <= init_byte(i);
    else if (RAM_WE && !RAM_WUNAL)
      for (int i = 0; i < nb(RAM_WWHBS); i++) ram[9'(RAM_WADDR + 32'(i))] <= RAM_DIN[8*i +: 8];
    RAM_DOUT <= {ram[9'(RAM_RADDR + 3)], ram[9'(RAM_RADDR + 2)], ram[9'(RAM_RADDR + 1)], ram[9'(RAM_RADDR)]};
  end

  function automatic logic pick_m(input logic r0, input logic r1);
`ifdef RAM_ARB_FIXED_PRIO_EN
    return !r0 && r1;
`else
    if (r0 && r1) return (m_run > 0 && m_run < MB) ? m_last : !m_last;
    return r1;
`endif
  endfunction

  task automatic set_port(input int p, input logic r, input logic we, input logic [1:0] sz,
                          input logic [31:0] a, input logic [31:0] d);
    if (p == 0) begin P0_REQ = r; P0_WE = we; P0_WHBS = sz; P0_ADDR = a; P0_WDATA = d; end
    else begin P1_REQ = r; P1_WE = we; P1_WHBS = sz; P1_ADDR = a; P1_WDATA = d; end
  endtask

  task automatic rand_port(input int p, input logic force_req);
    logic [1:0] s;
    s = ($urandom_range(0, 2) == 0) ? 2'b00 : ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b11;
    set_port(p, force_req | ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), s,
             32'($urandom_range(0, 63)), $urandom);
  endtask

  // one clock: check last response and this grant, then advance the model
  task automatic cycle();
    logic g, w, we;
    logic [1:0] sz;
    logic [31:0] a, d;
    @(negedge CLK);
    o_ack0 = P0_ACK; o_ack1 = P1_ACK; o_err0 = P0_ERR; o_err1 = P1_ERR;
    o_rd = e_p ? P1_RDATA : P0_RDATA;
    tests++; if (P0_ACK !== (e_v & ~RST & ~e_e & ~e_p)) begin fails++; $display("FAIL ack0: got %b want %b", P0_ACK, e_v & ~RST & ~e_e & ~e_p); end
    tests++; if (P1_ACK !== (e_v & ~RST & ~e_e & e_p)) begin fails++; $display("FAIL ack1: got %b want %b", P1_ACK, e_v & ~RST & ~e_e & e_p); end
    tests++; if (P0_ERR !== (e_v & ~RST & e_e & ~e_p)) begin fails++; $display("FAIL err0: got %b want %b", P0_ERR, e_v & ~RST & e_e & ~e_p); end
    tests++; if (P1_ERR !== (e_v & ~RST & e_e & e_p)) begin fails++; $display("FAIL err1: got %b want %b", P1_ERR, e_v & ~RST & e_e & e_p); end
    if (e_v && !RST && !e_e && e_load) begin
      tests++; if ((o_rd & e_mask) !== e_data) begin fails++; $display("FAIL rdata: got %h want %h", o_rd & e_mask, e_data); end
    end
    g = ~RST & (P0_REQ | P1_REQ);
    w = pick_m(P0_REQ, P1_REQ);
    we = w ? P1_WE : P0_WE;
    sz = w ? P1_WHBS : P0_WHBS;
    a = w ? P1_ADDR : P0_ADDR;
    d = w ? P1_WDATA : P0_WDATA;
    tests++; if (P0_GNT !== (g & ~w)) begin fails++; $display("FAIL gnt0: got %b want %b", P0_GNT, g & ~w); end
    tests++; if (P1_GNT !== (g & w)) begin fails++; $display("FAIL gnt1: got %b want %b", P1_GNT, g & w); end
    tests++; if (RAM_WE !== (g & we)) begin fails++; $display("FAIL ram_we: got %b want %b", RAM_WE, g & we); end
    if (g) begin
      tests++;
      if ((we ? {RAM_WADDR, RAM_DIN} : {RAM_RADDR, 32'h0}) !== {a, we ? d : 32'h0}) begin
        fails++; $display("FAIL ram_addr: got %h want %h", we ? RAM_WADDR : RAM_RADDR, a);
      end
    end
    e_v = g; e_p = w; e_load = ~we; e_e = unal(sz, a);
    e_mask = (nb(sz) == 4) ? 32'hFFFF_FFFF : (nb(sz) == 2) ? 32'h0000_FFFF : 32'h0000_00FF;
    e_data = 0;
    for (int i = 0; i < nb(sz); i++) e_data[8*i +: 8] = mem_m[9'(a + 32'(i))];
    g0 = g & ~w; g1 = g & w;
    if (g && seq_n < 10) begin seq_a[seq_n] = int'(w); seq_n++; end
    @(posedge CLK);
    if (RST) begin
      m_last = 1'b1; m_run = 0;
      for (int i = 0; i < 512; i++) mem_m[i] = init_byte(i);
    end else if (g) begin
      m_run = (w == m_last) ? ((m_run < MB) ? m_run + 1 : MB) : 1;
      m_last = w;
      if (we && !e_e) for (int i = 0; i < nb(sz); i++) mem_m[9'(a + 32'(i))] = d[8*i +: 8];
    end else begin
      m_run = 0;
    end
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    set_port(0, 0, 0, 0, 0, 0); set_port(1, 0, 0, 0, 0, 0);
    cycle(); cycle();
    RST = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    set_port(0, 1, 1, 2'b11, 32'h0, 32'h1234); set_port(1, 1, 0, 2'b11, 32'h4, 0);
    cycle(); cycle(); cycle();
    #2;
    tests++; if ({P0_GNT, P1_GNT, P0_ACK, P1_ACK, P0_ERR, P1_ERR, RAM_WE} !== 7'b0) begin
      fails++; $display("FAIL reset_outs: got %b want 0000000", {P0_GNT, P1_GNT, P0_ACK, P1_ACK, P0_ERR, P1_ERR, RAM_WE});
    end
    RST = 1'b0;
  endtask

  task automatic test_first_contention();
    logic [31:0] exp;
    do_reset();
    set_port(0, 1, 0, 2'b11, 32'h10, 0); set_port(1, 1, 0, 2'b11, 32'h20, 0);
    cycle();
    tests++; if (g0 !== 1'b1) begin fails++; $display("FAIL first_gnt: got gnt0=%b want 1", g0); end
    set_port(0, 0, 0, 0, 0, 0);
    cycle();
    exp = {init_byte(19), init_byte(18), init_byte(17), init_byte(16)};
    tests++; if (o_ack0 !== 1'b1 || o_rd !== exp) begin fails++; $display("FAIL first_load: got ack=%b data=%h want ack=1 data=%h", o_ack0, o_rd, exp); end
    set_port(1, 0, 0, 0, 0, 0);
    cycle();
  endtask

  task automatic test_burst();
    int want;
    do_reset();
    seq_n = 0;
    rand_port(0, 1); rand_port(1, 1);
    P0_WE = 0; P1_WE = 0;
    for (int c = 0; c < 12; c++) begin
      cycle();
      if (g0) begin rand_port(0, 1); P0_WE = 0; end
      if (g1) begin rand_port(1, 1); P1_WE = 0; end
    end
    for (int i = 0; i < 10; i++) begin
`ifdef RAM_ARB_FIXED_PRIO_EN
      want = 0;
`else
      want = (i / MB) % 2;
`endif
      tests++; if (seq_a[i] !== want) begin fails++; $display("FAIL burst[%0d]: got port %0d want %0d", i, seq_a[i], want); end
    end
    set_port(0, 0, 0, 0, 0, 0); set_port(1, 0, 0, 0, 0, 0);
    cycle();
  endtask

  task automatic test_unaligned_store();
    logic [31:0] exp;
    do_reset();
    set_port(1, 1, 1, 2'b01, 32'h3, 32'h0000_BEEF);
    cycle();
    set_port(1, 0, 0, 0, 0, 0);
    cycle();
    tests++; if (o_err1 !== 1'b1 || o_ack1 !== 1'b0) begin fails++; $display("FAIL unal_store: got err=%b ack=%b want err=1 ack=0", o_err1, o_ack1); end
    set_port(1, 1, 0, 2'b11, 32'h0, 0);
    cycle();
    set_port(1, 0, 0, 0, 0, 0);
    cycle();
    exp = {init_byte(3), init_byte(2), init_byte(1), init_byte(0)};
    tests++; if (o_ack1 !== 1'b1 || o_rd !== exp) begin fails++; $display("FAIL unal_nowrite: got ack=%b data=%h want ack=1 data=%h", o_ack1, o_rd, exp); end
  endtask

  task automatic test_byte_store_load();
    set_port(0, 1, 1, 2'b00, 32'h102, 32'h0000_00A5);
    cycle();
    set_port(0, 1, 0, 2'b11, 32'h100, 0);
    cycle();
    set_port(0, 0, 0, 0, 0, 0);
    cycle();
    tests++; if (o_ack0 !== 1'b1 || o_rd[23:16] !== 8'hA5) begin fails++; $display("FAIL byte_rmw: got ack=%b byte=%h want ack=1 byte=a5", o_ack0, o_rd[23:16]); end
  endtask

  task automatic test_reset_after_grant();
    set_port(0, 1, 0, 2'b11, 32'h40, 0);
    cycle();
    set_port(0, 0, 0, 0, 0, 0); set_port(1, 1, 0, 2'b11, 32'h44, 0);
    RST = 1'b1;
    cycle();
    tests++; if (o_ack0 !== 1'b0 || o_err0 !== 1'b0) begin fails++; $display("FAIL rst_suppress: got ack=%b err=%b want 0 0", o_ack0, o_err0); end
    RST = 1'b0;
    set_port(0, 1, 0, 2'b11, 32'h48, 0);
    cycle();
    tests++; if (g0 !== 1'b1) begin fails++; $display("FAIL post_rst_gnt: got gnt0=%b want 1", g0); end
    set_port(0, 0, 0, 0, 0, 0);
    cycle();
    set_port(1, 0, 0, 0, 0, 0);
    cycle();
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      cycle();
      if (g0 || !P0_REQ) rand_port(0, 0);
      if (g1 || !P1_REQ) rand_port(1, 0);
    end
    set_port(0, 0, 0, 0, 0, 0); set_port(1, 0, 0, 0, 0, 0);
    cycle();
  endtask

  initial begin
    test_reset();
    test_first_contention();
    test_burst();
    test_unaligned_store();
    test_byte_store_load();
    test_reset_after_grant();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
